alu_multicycle_rv32i: RTL

Execution-stage ALU for the RV32I/M core that consumes the 4-bit `ALU_op` code produced by the ALU decoder and the two operands, and returns a registered result. Base-ISA operations complete in one cycle. `mul`, `div` and `mod` run on an iterative shift-add / restoring-divide datapath. A valid/ready handshake on both sides lets the pipeline stall while an iterative operation is in flight.

---
 rtl/alu_multicycle_rv32i_if.sv | 25 ++
 rtl/alu_multicycle_rv32i.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_rv32i_if.sv
// Handshake bus between the ALU decoder/issue stage and the execution ALU.
// The master presents operations and consumes results; the slave is the ALU.
interface alu_multicycle_rv32i_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, ALU_op, A, B, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, ALU_op, A, B, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_multicycle_rv32i.sv
// RV32I/M execution ALU. Base operations finish in one cycle.
// mul uses an iterative shift-add datapath.
// div/mod use an iterative restoring divider on magnitudes, followed by a sign fix-up cycle.
module alu_multicycle_rv32i #(
    parameter int WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    alu_multicycle_rv32i_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             q_neg;
    logic             r_neg;
    logic             is_mod;

    logic             accept;
    logic             last_step;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] simple_result;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_by_zero;
    logic             div_overflow;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

    assign accept       = bus.in_valid && bus.in_ready;
    assign last_step    = (count == CW'(WIDTH - 1));
    assign shamt        = bus.B[CW-1:0];
    assign a_abs        = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs        = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign div_by_zero  = (bus.B == '0);
    assign div_overflow = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
    assign acc_next     = mplier[0] ? (acc + mcand) : acc;
    assign trial        = {rem, quo[WIDTH-1]};
    assign diff         = trial - {1'b0, divisor};

    // Single-cycle results for ops 0-12, written straight into the result register on accept
    always_comb begin
        simple_result = '0;
        case (bus.ALU_op)
            4'd0:    simple_result = bus.A + bus.B;
            4'd1:    simple_result = bus.A - bus.B;
            4'd2:    simple_result = bus.A ^ bus.B;
            4'd3:    simple_result = bus.A | bus.B;
            4'd4:    simple_result = bus.A & bus.B;
            4'd5:    simple_result = bus.A << shamt;
            4'd6:    simple_result = bus.A >> shamt;
            4'd7:    simple_result = $signed(bus.A) >>> shamt;
            4'd8:    simple_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'd9:    simple_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'd11:   simple_result = bus.B;
            4'd12:   simple_result = bus.A;
            default: simple_result = '0;
        endcase
    end

    // Control FSM and iterative datapath; accepts only happen in IDLE/DONE so they never collide with iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            result_q <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_mod   <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_step) begin
                        result_q <= acc_next;
                        state    <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (last_step) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_mod) begin
                        result_q <= r_neg ? -rem : rem;
                    end else begin
                        result_q <= q_neg ? -quo : quo;
                    end
                    state <= S_DONE;
                end
                default: ;
            endcase

            if (accept) begin
                case (bus.ALU_op)
                    4'd13: begin
                        mcand  <= bus.A;
                        mplier <= bus.B;
                        acc    <= '0;
                        count  <= '0;
                        state  <= S_MUL;
                    end
                    4'd14, 4'd15: begin
                        if (div_by_zero) begin
                            result_q <= (bus.ALU_op == 4'd14) ? '1 : bus.A;
                            state    <= S_DONE;
                        end else if (div_overflow) begin
                            result_q <= (bus.ALU_op == 4'd14) ? bus.A : '0;
                            state    <= S_DONE;
                        end else begin
                            quo     <= a_abs;
                            divisor <= b_abs;
                            rem     <= '0;
                            q_neg   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            r_neg   <= bus.A[WIDTH-1];
                            is_mod  <= (bus.ALU_op == 4'd15);
                            count   <= '0;
                            state   <= S_DIV;
                        end
                    end
                    default: begin
                        result_q <= simple_result;
                        state    <= S_DONE;
                    end
                endcase
            end else if (state == S_DONE && bus.out_ready) begin
                state <= S_IDLE;
            end
        end
    end
endmodule
